// File: rtl/game_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | game_ctrl : two-player dice match controller, best-of-ROUNDS     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module game_ctrl #(
  parameter int ROUNDS      = 3,
  parameter int SHOW_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic [2:0] dice_val,
  output logic [2:0] dice1,
  output logic [2:0] dice2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] round_cnt,
  output logic       times,
  output logic       is_final,
  output logic       is_finish,
  output logic       turn
);

  localparam int            TW         = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(SHOW_CYCLES - 1);
  localparam logic [3:0]    ROUNDS_C   = 4'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_P1 = 3'd1,
    S_WAIT_P2 = 3'd2,
    S_SHOW    = 3'd3,
    S_FINAL   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    dice1_q, dice1_d, dice2_q, dice2_d;
  logic [3:0]    score1_q, score1_d, score2_q, score2_d, round_q, round_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          times_q, times_d, final_q, final_d, turn_q, turn_d;
  logic          clear;
  logic [2:0]    roll_val;

  // A die face can only be 1..6; out-of-range samples count as a 1.
  assign roll_val = (dice_val == 3'd0 || dice_val == 3'd7) ? 3'd1 : dice_val;

  always_comb begin
    state_d  = state_q;
    dice1_d  = dice1_q;
    dice2_d  = dice2_q;
    score1_d = score1_q;
    score2_d = score2_q;
    round_d  = round_q;
    timer_d  = timer_q;
    clear    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = S_WAIT_P1;
        end
      end
      S_WAIT_P1: begin
        if (start) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end else if (btn_p1) begin
          dice1_d = roll_val;
          state_d = S_WAIT_P2;
        end
      end
      S_WAIT_P2: begin
        if (start) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end else if (btn_p2) begin
          dice2_d = roll_val;
          timer_d = TIMER_LOAD;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (start) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          // Ties leave all counters alone so the round is simply replayed.
          if (round_q < ROUNDS_C) begin
            if (dice1_q > dice2_q) begin
              score1_d = score1_q + 4'd1;
              round_d  = round_q + 4'd1;
            end else if (dice1_q < dice2_q) begin
              score2_d = score2_q + 4'd1;
              round_d  = round_q + 4'd1;
            end
          end
          state_d = (round_d == ROUNDS_C) ? S_FINAL : S_WAIT_P1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_FINAL: begin
        if (start) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        clear   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (clear) begin
      dice1_d  = '0;
      dice2_d  = '0;
      score1_d = '0;
      score2_d = '0;
      round_d  = '0;
      timer_d  = '0;
    end

    times_d = (state_d == S_IDLE) || (state_d == S_FINAL);
    final_d = (state_d == S_FINAL);
    turn_d  = (state_d == S_WAIT_P2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      dice1_q  <= '0;
      dice2_q  <= '0;
      score1_q <= '0;
      score2_q <= '0;
      round_q  <= '0;
      timer_q  <= '0;
      times_q  <= 1'b1;
      final_q  <= 1'b0;
      turn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dice1_q  <= dice1_d;
      dice2_q  <= dice2_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      round_q  <= round_d;
      timer_q  <= timer_d;
      times_q  <= times_d;
      final_q  <= final_d;
      turn_q   <= turn_d;
    end
  end

  assign dice1     = dice1_q;
  assign dice2     = dice2_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign round_cnt = round_q;
  assign times     = times_q;
  assign is_final  = final_q;
  assign is_finish = final_q;
  assign turn      = turn_q;

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter ROUNDS, default 3, number of decided rounds per match; SHALL be odd, 1..15.
REQ-002 Parameter SHOW_CYCLES, default 100000, clk cycles both dice are displayed before scoring; SHALL be >= 1.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle pulse: begin match / abort / restart.
REQ-006 btn_p1  in  1  single-cycle pulse, player 1 roll request.
REQ-007 btn_p2  in  1  single-cycle pulse, player 2 roll request.
REQ-008 dice_val  in  3  free-running random value, nominally 1..6.
REQ-009 dice1, dice2  out  3 each  latched rolls of player 1 / player 2.
REQ-010 score1, score2  out  4 each  rounds won by player 1 / player 2.
REQ-011 round_cnt  out  4  decided rounds so far.
REQ-012 times  out  1  high in IDLE and FINAL (LED animation enable), low otherwise.
REQ-013 is_final, is_finish  out  1 each  high only in FINAL.
REQ-014 turn  out  1  0 = player 1 expected, 1 = player 2 expected; 0 outside WAIT_P2.

Function
REQ-015 All outputs SHALL be registered; FSM states IDLE, WAIT_P1, WAIT_P2, SHOW, FINAL.
REQ-016 IDLE: times=1; start -> clear scores, round_cnt, dice1, dice2 -> WAIT_P1 next cycle.
REQ-017 WAIT_P1: btn_p1 -> dice1 <= dice_val -> WAIT_P2; btn_p2 ignored.
REQ-018 WAIT_P2: turn=1; btn_p2 -> dice2 <= dice_val, load timer -> SHOW; btn_p1 ignored.
REQ-019 dice_val of 0 or 7 SHALL be latched as 1.
REQ-020 SHOW SHALL last exactly SHOW_CYCLES cycles; buttons ignored.
REQ-021 On SHOW's last cycle: dice1>dice2 -> score1+1, round_cnt+1; dice1<dice2 -> score2+1, round_cnt+1; equal -> no change (round replayed).
REQ-022 After SHOW: updated round_cnt == ROUNDS -> FINAL, else WAIT_P1.
REQ-023 FINAL: times=is_final=is_finish=1; scores, dice, round_cnt held; buttons ignored.
REQ-024 start in FINAL -> IDLE with scores, round_cnt, dice cleared.
REQ-025 start in WAIT_P1, WAIT_P2 or SHOW -> abort to IDLE, all counters and dice cleared.
REQ-026 start SHALL take priority over any button pulse in the same cycle.
REQ-027 btn_p1 and btn_p2 together in WAIT_P1 -> only btn_p1 accepted; btn_p2 not carried over.
REQ-028 Score/round counters SHALL never exceed ROUNDS; no wrap-around possible.

Reset
REQ-029 rst low SHALL immediately force IDLE, times=1, is_final=is_finish=0, turn=0, all scores/counters/dice/timer 0.
REQ-030 rst deassertion SHALL take effect on the next rising clk; reset mid-match discards the match.

Verification (ROUNDS=3, SHOW_CYCLES=4)
REQ-031 Reset, then idle 10 cycles -> times=1, is_final=0, all counters 0.
REQ-032 start; btn_p1 dice_val=5; btn_p2 dice_val=2 -> 4 SHOW cycles, then score1=1, round_cnt=1, state WAIT_P1.
REQ-033 Rolls 3/3 -> scores and round_cnt unchanged; next rolls 1/6 -> score2=1.
REQ-034 Three P1 wins -> score1=3, is_final=is_finish=times=1; start -> IDLE, scores 0.
REQ-035 btn_p1+btn_p2 same cycle in WAIT_P1 -> dice1 latched, turn=1, dice2 unchanged; start with btn_p2 in WAIT_P2 -> IDLE.
REQ-036 rst asserted mid-SHOW -> outputs at reset values asynchronously; dice_val=0 roll -> dice1=1.
